pipelined_logic_unit: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational logic circuit.
- Performs the same eight bitwise operations on WIDTH-bit operands through a 2-stage valid/ready pipeline.
- Adds an accumulator mode (operand A replaced by the previous result), result status flags, and a transfer counter.
- Sits between the operand source and the result consumer in the datapath test harness.

---
 rtl/pipelined_logic_unit_if.sv | 43 ++++
 rtl/pipelined_logic_unit.sv | 175 +++++++++++++++++
 tb/tb_pipelined_logic_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_logic_unit_if.sv
// -----------------------------------------------------------------------------
// pipelined_logic_unit_if
//   Operand/result bundle for pipelined_logic_unit.
//
//   Operand side  : in_valid/in_ready handshake carrying a, b, op, acc_mode
//                   and acc_clr.
//   Result side   : out_valid/out_ready handshake carrying result, zero and
//                   parity.
//   Status        : ops_done, the saturating count of completed result
//                   transfers.
//
//   Modports
//     slave  - the logic unit (consumes operands, produces results)
//     master - the harness (produces operands, consumes results)
// -----------------------------------------------------------------------------
interface pipelined_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] ops_done;

    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        output in_ready, out_valid, result, zero, parity, ops_done
    );

    modport master (
        output in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        input  in_ready, out_valid, result, zero, parity, ops_done
    );
endinterface

// File: rtl/pipelined_logic_unit.sv
// -----------------------------------------------------------------------------
// pipelined_logic_unit
//   Two-stage valid/ready pipeline applying one of eight bitwise operations to
//   WIDTH-bit operands. Operand A may be replaced by an internal accumulator
//   that captures every result computed in stage 1.
//
//   Ports
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - pipelined_logic_unit_if.slave
//                operand side : in_valid/in_ready, a, b, op, acc_mode, acc_clr
//                result side  : out_valid/out_ready, result, zero, parity
//                status       : ops_done (saturating transfer count)
//
//   Op encoding (A' = acc_mode ? acc : a)
//     0 AND   1 OR    2 XOR   3 ~A'
//     4 NOR   5 XNOR  6 ~b    7 NAND
//
//   Stage 1 holds the computed value; stage 2 holds the registered result and
//   its flags. Each stage advances independently so a full pipeline can take
//   in, shift and emit one beat in the same cycle.
// -----------------------------------------------------------------------------
module pipelined_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_logic_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // Operation table
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (sel)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~x;
            3'd4:    r = ~(x | y);
            3'd5:    r = ~(x ^ y);
            3'd6:    r = ~y;
            default: r = ~(x & y);
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             zero_q,     zero_d;
    logic             parity_q,   parity_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic             in_ready;
    logic             accept;
    logic             advance;
    logic             drain;
    logic [WIDTH-1:0] acc_src;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] f_val;

    // Stage 1 can take a beat if it is empty, or if its current beat is
    // guaranteed to move into stage 2 this cycle.
    assign in_ready = !s1_valid_q || !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign advance  = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign drain    = out_valid_q && bus.out_ready;

    // Clear-then-operate: a clear arriving with an accepted beat zeroes the
    // accumulator before it is used as A'.
    assign acc_src  = bus.acc_clr ? '0 : acc_q;
    assign a_eff    = bus.acc_mode ? acc_src : bus.a;
    assign f_val    = logic_op(bus.op, a_eff, bus.b);

    // -------------------------------------------------------------------------
    // Stage 1 and accumulator next state
    // -------------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        acc_d      = acc_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = f_val;
            // Accumulator follows every accepted result, even in normal mode,
            // so switching into accumulator mode chains from the last beat.
            acc_d      = f_val;
        end else begin
            if (advance) begin
                s1_valid_d = 1'b0;
            end
            if (bus.acc_clr) begin
                acc_d = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 and transfer counter next state
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        cnt_d       = cnt_q;

        if (advance) begin
            out_valid_d = 1'b1;
            result_d    = s1_data_q;
            zero_d      = (s1_data_q == '0);
            parity_d    = ^s1_data_q;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        if (drain && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            cnt_q       <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.ops_done  = cnt_q;

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_logic_unit
//   Drives a WIDTH=8 / CNT_W=16 unit and a CNT_W=3 twin with identical
//   stimulus. A queue-based model (2-deep buffer, results computed from the op
//   table) predicts every output; directed sections pin the model with
//   literal results.
// -----------------------------------------------------------------------------
module tb_pipelined_logic_unit;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_logic_unit_if #(.WIDTH(W), .CNT_W(16)) bus ();
    pipelined_logic_unit_if #(.WIDTH(W), .CNT_W(3))  bus3 ();

    assign bus3.in_valid  = bus.in_valid;
    assign bus3.a         = bus.a;
    assign bus3.b         = bus.b;
    assign bus3.op        = bus.op;
    assign bus3.acc_mode  = bus.acc_mode;
    assign bus3.acc_clr   = bus.acc_clr;
    assign bus3.out_ready = bus.out_ready;

    pipelined_logic_unit #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    pipelined_logic_unit #(.WIDTH(W), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [W-1:0] mq[$];      // beats inside the unit, oldest first
    bit           m_vis;      // oldest beat is presented on the output
    int           m_cnt;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_ap, m_r;
    bit           m_drain, m_rdy;

    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~x;
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return ~y;
            default: return ~(x & y);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_vis = 0;
            m_cnt = 0;
            m_acc = '0;
        end else begin
            m_drain = m_vis && bus.out_ready;
            m_rdy   = (mq.size() < 2) || bus.out_ready;
            if (m_drain) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            // Beats accepted earlier become visible; this cycle's beat cannot.
            m_vis = (mq.size() > 0);
            if (bus.in_valid && m_rdy) begin
                m_ap = bus.acc_mode ? (bus.acc_clr ? '0 : m_acc) : bus.a;
                m_r  = ref_op(bus.op, m_ap, bus.b);
                mq.push_back(m_r);
                m_acc = m_r;
            end else if (bus.acc_clr) begin
                m_acc = '0;
            end
        end
    end

    // ------------------------------------------------------ transfer logging
    logic [W+1:0] got[$];    // {parity, zero, result} per output transfer
    bit           fired;

    always @(posedge clk) begin
        fired = bus.in_valid && bus.in_ready;
        if (rst_n && bus.out_valid && bus.out_ready)
            got.push_back({bus.parity, bus.zero, bus.result});
    end

    // -------------------------------------------------------- compare process
    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", bus.in_ready, (mq.size() < 2) || bus.out_ready);
            chk("out_valid", bus.out_valid, m_vis);
            if (m_vis && mq.size() > 0) begin
                chk("result", bus.result, mq[0]);
                chk("zero", bus.zero, mq[0] == '0);
                chk("parity", bus.parity, ^mq[0]);
            end
            chk("ops_done", bus.ops_done, m_cnt);
            chk("ops_done_sat", bus3.ops_done, (m_cnt > 7) ? 7 : m_cnt);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic am, input logic cl);
        bus.in_valid = 1; bus.op = o; bus.a = av; bus.b = bv;
        bus.acc_mode = am; bus.acc_clr = cl;
        cyc();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 0; bus.acc_clr = 0;
        repeat (n) cyc();
    endtask

    logic [W-1:0] sweep_exp[8] = '{8'h48, 8'hEB, 8'hA3, 8'h35, 8'h14, 8'h5C, 8'h96, 8'hB7};
    logic [W-1:0] chain_exp[4] = '{8'h0F, 8'hF0, 8'h0F, 8'h00};
    logic [W-1:0] clr_exp[3]   = '{8'h3C, 8'h81, 8'h81};

    initial begin
        int k;
        int guard;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.op = 0;
        bus.acc_mode = 0; bus.acc_clr = 0; bus.out_ready = 1;
        #12 rst_n = 1;
        chk_on = 1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.zero, bus.parity}, 0);
        chk("rst_ops_done", bus.ops_done, 0);
        @(negedge clk);

        // Op sweep, back to back.
        got.delete();
        for (int i = 0; i < 8; i++) beat(3'(i), 8'hCA, 8'h69, 0, 0);
        idle(4);
        chk("sweep_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("sweep_op%0d", i), got[i][W-1:0], sweep_exp[i]);
        if (got.size() >= 2) begin
            chk("sweep_parity48", got[0][W+1], 0);
            chk("sweep_parityEB", got[1][W+1], 0);
        end
        chk("sweep_ops_done", bus.ops_done, 8);

        // Accumulator chain.
        got.delete();
        bus.acc_clr = 1; bus.in_valid = 0; cyc();
        beat(3'd1, 8'hAA, 8'h0F, 1, 0);
        beat(3'd2, 8'hAA, 8'hFF, 1, 0);
        beat(3'd3, 8'hAA, 8'h55, 1, 0);
        beat(3'd0, 8'hAA, 8'h00, 1, 0);
        idle(4);
        chk("chain_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk($sformatf("chain_res%0d", i), got[i][W-1:0], chain_exp[i]);
            chk($sformatf("chain_zero%0d", i), got[i][W], (i == 3));
        end
        chk("sat_ops_done7", bus3.ops_done, 7);

        // Clear and operate in the same cycle.
        got.delete();
        beat(3'd1, 8'h3C, 8'h00, 0, 0);
        beat(3'd1, 8'hFF, 8'h81, 1, 1);
        beat(3'd1, 8'hFF, 8'h00, 1, 0);
        idle(4);
        chk("clr_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("clr_res%0d", i), got[i][W-1:0], clr_exp[i]);

        // Backpressure.
        got.delete();
        k = 0;
        bus.out_ready = 0;
        repeat (4) begin
            beat(3'd1, 8'(8'h10 + k), 8'h00, 0, 0);
            if (fired) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_hold", bus.result, 8'h10);
        bus.out_ready = 1;
        guard = 0;
        while (k < 6 && guard < 30) begin
            beat(3'd1, 8'(8'h10 + k), 8'h00, 0, 0);
            if (fired) k++;
            guard++;
        end
        chk("bp_timeout", guard < 30, 1);
        idle(4);
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk($sformatf("bp_order%0d", i), got[i][W-1:0], 8'(8'h10 + i));
        chk("bp_ops_done", bus.ops_done, 21);

        // Randomized traffic.
        repeat (400) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(2) != 0);
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            bus.op        = 3'($urandom);
            bus.acc_mode  = 1'($urandom);
            bus.acc_clr   = ($urandom_range(7) == 0);
            cyc();
        end

        // Asynchronous reset with both stages full.
        bus.out_ready = 0; bus.acc_clr = 0; bus.acc_mode = 0;
        repeat (3) beat(3'd1, 8'h77, 8'h00, 0, 0);
        chk("full_in_ready", bus.in_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_result", bus.result, 0);
        chk("arst_flags", {bus.zero, bus.parity}, 0);
        chk("arst_ops_done", bus.ops_done, 0);
        chk("arst_ops_done3", bus3.ops_done, 0);
        bus.in_valid = 0; bus.out_ready = 1;
        cyc();
        #2 rst_n = 1;
        got.delete();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_idle", bus.out_valid, 0);
        end
        beat(3'd1, 8'h5A, 8'h00, 0, 0);
        idle(3);
        chk("post_rst_count", got.size(), 1);
        if (got.size() > 0) chk("post_rst_res", got[0][W-1:0], 8'h5A);

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
